// File: rtl/computie_bus_trigger_capture.sv
// Triggered capture engine for the Computie bus debugger.
// Synchronises the asynchronous bus, assembles one record per completed bus
// cycle into a circular buffer while armed, stops after a trigger plus a
// post-trigger window, then streams a framed dump over valid/ready.
module computie_bus_trigger_capture #(
   parameter int BITWIDTH    = 32,
   parameter int DEPTH       = 32,
   parameter int PRE_TRIGGER = 8
) (
   input  logic                comm_clock,
   input  logic                reset,
   input  logic                arm,
   input  logic                force_trigger,
   input  logic [BITWIDTH-1:0] trigger_addr,
   input  logic [BITWIDTH-1:0] trigger_mask,
   input  logic [1:0]          trigger_rw_mode,
   input  logic                cb_addr_strobe,
   input  logic                cb_data_strobe,
   input  logic                cb_read_write,
   input  logic [BITWIDTH-1:0] cb_addr_data_bus,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic                armed,
   output logic                triggered,
   output logic                dump_end
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 8 + 2 * BITWIDTH;
   localparam int RB = 1 + 2 * (BITWIDTH / 8);
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [CW-1:0] POST_INIT = CW'(DEPTH - PRE_TRIGGER - 1);
   localparam logic [3:0]    LAST_BYTE = 4'(RB - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DUMP} state_t;
   typedef enum logic [1:0] {D_HDR, D_CNT, D_REC, D_FIN} dphase_t;

   // Fill level saturates at DEPTH once the ring has wrapped.
   function automatic logic [CW-1:0] fill_inc(input logic [CW-1:0] f);
      return (f == FULL) ? f : f + CW'(1);
   endfunction

   state_t               state, state_nx;
   dphase_t              dph;

   logic                 as_p0, as_p1, as_p2;
   logic                 ds_p0, ds_p1, ds_p2;
   logic                 rw_p0, rw_p1;
   logic [BITWIDTH-1:0]  bus_p0, bus_p1;
   logic                 as_fall, as_rise, ds_hit;

   logic [BITWIDTH-1:0]  rec_addr, rec_data;
   logic                 rec_rw, rec_seen;

   logic                 vld_p3;
   logic [BITWIDTH-1:0]  c_addr_p3, c_data_p3;
   logic                 c_rw_p3, c_seen_p3;

   logic [AW-1:0]        wr_ptr, rd_idx, ram_addr, start_idx;
   logic [CW-1:0]        fill, post_count, recs_left, reads_left;
   logic                 force_pend, rw_ok, addr_hit;
   logic                 ram_we, trig_rec;
   logic [EW-1:0]        ram_wdata, ram_rdata, rec_sh;
   logic [EW-1:0]        mem [DEPTH];

   logic                 rd_go, rd_pend, buf_vld;
   logic [3:0]           byte_idx;
   logic                 slot_free, byte_take, rec_last, dump_done;

   // ---- stage p0..p2: strobe synchronisers plus edge register
   always_ff @(posedge comm_clock) begin
      if (reset) begin
         as_p0 <= 1'b1; as_p1 <= 1'b1; as_p2 <= 1'b1;
         ds_p0 <= 1'b1; ds_p1 <= 1'b1; ds_p2 <= 1'b1;
      end else begin
         as_p0 <= cb_addr_strobe; as_p1 <= as_p0; as_p2 <= as_p1;
         ds_p0 <= cb_data_strobe; ds_p1 <= ds_p0; ds_p2 <= ds_p1;
      end
   end

   // Bus value and direction travel alongside the strobes, two flops deep.
   always_ff @(posedge comm_clock) begin
      rw_p0  <= cb_read_write;
      rw_p1  <= rw_p0;
      bus_p0 <= cb_addr_data_bus;
      bus_p1 <= bus_p0;
   end

   assign as_fall = as_p2 & ~as_p1;
   assign as_rise = ~as_p2 & as_p1;
   assign ds_hit  = ds_p2 & ~ds_p1 & ~as_p1;

   // Latch address/data from the bus and form the committed record.
   always_ff @(posedge comm_clock) begin
      if (as_fall) begin
         rec_addr <= bus_p1;
         rec_rw   <= rw_p1;
      end
      if (ds_hit)
         rec_data <= bus_p1;
      if (as_rise) begin
         c_addr_p3 <= rec_addr;
         c_data_p3 <= rec_seen ? rec_data : '0;
         c_rw_p3   <= rec_rw;
      end
   end

   // ---- stage p3: record commit strobe and data-seen tracking
   always_ff @(posedge comm_clock) begin
      if (reset) begin
         rec_seen  <= 1'b0;
         vld_p3    <= 1'b0;
         c_seen_p3 <= 1'b0;
      end else begin
         vld_p3 <= as_rise;
         if (as_fall)
            rec_seen <= 1'b0;
         else if (ds_hit)
            rec_seen <= 1'b1;
         if (as_rise)
            c_seen_p3 <= rec_seen;
      end
   end

   // Trigger qualification on the committed record.
   always_comb begin
      rw_ok = 1'b0;
      case (trigger_rw_mode)
         2'd0:    rw_ok = 1'b1;
         2'd1:    rw_ok = c_rw_p3;
         2'd2:    rw_ok = ~c_rw_p3;
         default: rw_ok = 1'b0;
      endcase
   end

   assign addr_hit  = ((c_addr_p3 ^ trigger_addr) & trigger_mask) == '0;
   assign ram_we    = vld_p3 & ((state == S_ARMED) | (state == S_POST)) & ~arm;
   assign trig_rec  = ram_we & (state == S_ARMED) & (force_pend | (addr_hit & rw_ok));
   assign ram_wdata = {5'b0, trig_rec, c_seen_p3, c_rw_p3, c_addr_p3, c_data_p3};
   assign start_idx = (fill == FULL) ? wr_ptr : '0;
   assign ram_addr  = (state == S_DUMP) ? rd_idx : wr_ptr;

   // Dump handshake helpers.
   assign slot_free = ~out_valid | out_ready;
   assign byte_take = (state == S_DUMP) & (dph == D_REC) & slot_free & buf_vld;
   assign rec_last  = byte_take & (byte_idx == LAST_BYTE);
   assign rd_go     = (state == S_DUMP) & (dph != D_HDR) & (reads_left != '0) &
                      ~rd_pend & (~buf_vld | rec_last);
   assign dump_done = (state == S_DUMP) & (dph == D_FIN) & out_ready;

   // State register.
   always_ff @(posedge comm_clock) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_nx  = state;
      armed     = 1'b0;
      triggered = 1'b0;
      case (state)
         S_IDLE: begin
            if (arm) state_nx = S_ARMED;
         end
         S_ARMED: begin
            armed = 1'b1;
            if (arm)
               state_nx = S_ARMED;
            else if (trig_rec)
               state_nx = (POST_INIT == '0) ? S_DUMP : S_POST;
         end
         S_POST: begin
            armed     = 1'b1;
            triggered = 1'b1;
            if (arm)
               state_nx = S_ARMED;
            else if (ram_we && post_count == CW'(1))
               state_nx = S_DUMP;
         end
         S_DUMP: begin
            triggered = 1'b1;
            if (dump_done) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Write pointer, fill level, post-trigger window and pending force.
   always_ff @(posedge comm_clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         fill       <= '0;
         post_count <= '0;
         force_pend <= 1'b0;
      end else if (arm && state != S_DUMP) begin
         wr_ptr     <= '0;
         fill       <= '0;
         force_pend <= 1'b0;
      end else begin
         if (force_trigger && state == S_ARMED)
            force_pend <= 1'b1;
         if (ram_we) begin
            wr_ptr <= wr_ptr + AW'(1);
            fill   <= fill_inc(fill);
            if (trig_rec) begin
               force_pend <= 1'b0;
               post_count <= POST_INIT;
            end else if (state == S_POST) begin
               post_count <= post_count - CW'(1);
            end
         end
      end
   end

   // Single-port buffer, one-cycle read latency.
   always_ff @(posedge comm_clock) begin
      if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Record shift register feeding bytes MSB first.
   always_ff @(posedge comm_clock) begin
      if (rd_pend)
         rec_sh <= ram_rdata;
      else if (byte_take)
         rec_sh <= rec_sh << 8;
   end

   // Dump framing: header, count, then records read oldest first.
   always_ff @(posedge comm_clock) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= 8'h00;
         dump_end   <= 1'b0;
         dph        <= D_HDR;
         rd_pend    <= 1'b0;
         buf_vld    <= 1'b0;
         rd_idx     <= '0;
         byte_idx   <= '0;
         recs_left  <= '0;
         reads_left <= '0;
      end else begin
         dump_end <= 1'b0;
         rd_pend  <= rd_go;
         if (state != S_DUMP) begin
            dph       <= D_HDR;
            out_valid <= 1'b0;
            buf_vld   <= 1'b0;
         end else begin
            if (rd_go) begin
               rd_idx     <= rd_idx + AW'(1);
               reads_left <= reads_left - CW'(1);
            end
            case (dph)
               D_HDR: begin
                  out_valid  <= 1'b1;
                  out_data   <= 8'hA5;
                  dph        <= D_CNT;
                  rd_idx     <= start_idx;
                  reads_left <= fill;
                  recs_left  <= fill;
                  byte_idx   <= '0;
               end
               D_CNT: begin
                  if (slot_free) begin
                     out_data <= 8'(fill);
                     dph      <= (fill == '0) ? D_FIN : D_REC;
                  end
               end
               D_REC: begin
                  if (slot_free) begin
                     if (buf_vld) begin
                        out_valid <= 1'b1;
                        out_data  <= rec_sh[EW-1 -: 8];
                        if (byte_idx == LAST_BYTE) begin
                           byte_idx  <= '0;
                           buf_vld   <= 1'b0;
                           recs_left <= recs_left - CW'(1);
                           if (recs_left == CW'(1)) dph <= D_FIN;
                        end else begin
                           byte_idx <= byte_idx + 4'd1;
                        end
                     end else begin
                        out_valid <= 1'b0;
                     end
                  end
               end
               D_FIN: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     dump_end  <= 1'b1;
                  end
               end
               default: dph <= D_HDR;
            endcase
            if (rd_pend)
               buf_vld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_computie_bus_trigger_capture.sv
// Directed bench for the bus trigger capture engine. Two instances share the
// bus: dut_a keeps 2 records before the trigger, dut_b stops right at the
// trigger record so small captures dump immediately.
module tb_computie_bus_trigger_capture;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, arm_a, arm_b, force_trigger, out_ready;
   logic [31:0] trigger_addr, trigger_mask;
   logic [1:0]  trigger_rw_mode;
   logic        as_n, ds_n, rw;
   logic [31:0] bus;

   logic        ov_a, armed_a, trig_a, de_a;
   logic [7:0]  od_a;
   logic        ov_b, armed_b, trig_b, de_b;
   logic [7:0]  od_b;

   logic        sel;
   logic        ov, de;
   logic [7:0]  od;
   assign ov = sel ? ov_b : ov_a;
   assign od = sel ? od_b : od_a;
   assign de = sel ? de_b : de_a;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   int          end_pulses;
   int          stall_viol;

   computie_bus_trigger_capture #(.BITWIDTH(32), .DEPTH(8), .PRE_TRIGGER(2)) dut_a (
      .comm_clock(clk), .reset(reset), .arm(arm_a), .force_trigger(force_trigger),
      .trigger_addr(trigger_addr), .trigger_mask(trigger_mask),
      .trigger_rw_mode(trigger_rw_mode), .cb_addr_strobe(as_n),
      .cb_data_strobe(ds_n), .cb_read_write(rw), .cb_addr_data_bus(bus),
      .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
      .armed(armed_a), .triggered(trig_a), .dump_end(de_a));

   computie_bus_trigger_capture #(.BITWIDTH(32), .DEPTH(8), .PRE_TRIGGER(7)) dut_b (
      .comm_clock(clk), .reset(reset), .arm(arm_b), .force_trigger(force_trigger),
      .trigger_addr(trigger_addr), .trigger_mask(trigger_mask),
      .trigger_rw_mode(trigger_rw_mode), .cb_addr_strobe(as_n),
      .cb_data_strobe(ds_n), .cb_read_write(rw), .cb_addr_data_bus(bus),
      .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
      .armed(armed_b), .triggered(trig_b), .dump_end(de_b));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_arm(input bit b);
      if (b) arm_b = 1'b1; else arm_a = 1'b1;
      @(negedge clk);
      arm_a = 1'b0;
      arm_b = 1'b0;
   endtask

   task automatic bus_cycle(input logic [31:0] addr, input logic r,
                            input logic [31:0] data, input bit with_ds);
      bus = addr;
      rw  = r;
      idle(2);
      as_n = 1'b0;
      idle(4);
      if (with_ds) begin
         bus = data;
         idle(2);
         ds_n = 1'b0;
         idle(3);
         ds_n = 1'b1;
      end else begin
         idle(5);
      end
      idle(2);
      as_n = 1'b1;
      idle(6);
   endtask

   task automatic exp_rec(input logic [7:0] f, input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back(f);
      for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
   endtask

   // Accept dump bytes from the selected DUT; stop_after=0 runs to dump_end.
   task automatic collect(input bit rnd, input int stop_after);
      bit         stalled = 1'b0;
      bit         stop = 1'b0;
      logic [7:0] held = 8'h00;
      int         after_end = 0;
      got.delete();
      end_pulses = 0;
      stall_viol = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (stop) break;
         if (stalled && (ov !== 1'b1 || od !== held)) stall_viol++;
         if (de === 1'b1) end_pulses++;
         if (end_pulses > 0) begin
            after_end++;
            if (ov === 1'b1) stall_viol++;
            if (after_end > 4) break;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ov === 1'b1 && out_ready) got.push_back(od);
         stalled = (ov === 1'b1) && !out_ready;
         held    = od;
         if (stop_after != 0 && got.size() == stop_after) stop = 1'b1;
      end
      out_ready = 1'b0;
   endtask

   task automatic compare_dump(input string name);
      check({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got.size())
            check($sformatf("%s_b%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
      check({name, "_dump_end_pulses"}, 32'(end_pulses), 32'd1);
      check({name, "_stall_hold"}, 32'(stall_viol), 32'd0);
   endtask

   task automatic test1_capture(input string name, input bit rnd);
      pulse_arm(1'b0);
      check({name, "_armed"}, 32'(armed_a), 32'd1);
      check({name, "_trig_pre"}, 32'(trig_a), 32'd0);
      for (int k = 0; k < 20; k++) begin
         bus_cycle(32'h0000_0FF0 + 32'(4 * k), k[0], 32'hC0DE_0000 + 32'(k), 1'b1);
         if (k == 4) begin
            check({name, "_post_armed"}, 32'(armed_a), 32'd1);
            check({name, "_post_trig"}, 32'(trig_a), 32'd1);
         end
         if (k == 9) begin
            check({name, "_dump_armed"}, 32'(armed_a), 32'd0);
            check({name, "_dump_trig"}, 32'(trig_a), 32'd1);
         end
      end
      collect(rnd, 0);
      compare_dump(name);
      check({name, "_end_trig"}, 32'(trig_a), 32'd0);
   endtask

   initial begin
      reset = 1'b1; arm_a = 1'b0; arm_b = 1'b0; force_trigger = 1'b0;
      out_ready = 1'b0; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; bus = '0;
      trigger_addr = 32'h0000_1000; trigger_mask = 32'hFFFF_FFFF;
      trigger_rw_mode = 2'd0; sel = 1'b0;
      idle(4);
      reset = 1'b0;
      idle(1);
      check("rst_out_valid", 32'(ov_a), 32'd0);
      check("rst_out_data", 32'(od_a), 32'h00);
      check("rst_armed", 32'(armed_a), 32'd0);
      check("rst_triggered", 32'(trig_a), 32'd0);
      check("rst_dump_end", 32'(de_a), 32'd0);
      check("rst_b_valid", 32'(ov_b), 32'd0);

      // Matching cycle while idle is discarded.
      bus_cycle(32'h0000_1000, 1'b1, 32'h0000_DEAD, 1'b1);
      check("idle_armed", 32'(armed_a), 32'd0);
      check("idle_trig", 32'(trig_a), 32'd0);

      // Trigger at k=4, wrap: oldest-first k=2..9.
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h08);
      for (int k = 2; k <= 9; k++)
         exp_rec({5'b0, (k == 4), 1'b1, k[0]}, 32'h0000_0FF0 + 32'(4 * k),
                 32'hC0DE_0000 + 32'(k));
      test1_capture("t1", 1'b0);
      test1_capture("t5", 1'b1);

      // Forced trigger on dut_b: 3 writes, force, 1 read.
      sel = 1'b1;
      pulse_arm(1'b1);
      for (int i = 0; i < 3; i++)
         bus_cycle(32'h0000_2000 + 32'(4 * i), 1'b0, 32'h1111_1111 * 32'(i + 1), 1'b1);
      force_trigger = 1'b1;
      @(negedge clk);
      force_trigger = 1'b0;
      check("t2_force_no_trig", 32'(trig_b), 32'd0);
      bus_cycle(32'h0000_3000, 1'b1, 32'h55AA_1234, 1'b1);
      check("t2_trig", 32'(trig_b), 32'd1);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h04);
      exp_rec(8'h02, 32'h0000_2000, 32'h1111_1111);
      exp_rec(8'h02, 32'h0000_2004, 32'h2222_2222);
      exp_rec(8'h02, 32'h0000_2008, 32'h3333_3333);
      exp_rec(8'h07, 32'h0000_3000, 32'h55AA_1234);
      collect(1'b0, 0);
      compare_dump("t2");

      // Write-only mode: the read at the match address is not a trigger.
      trigger_rw_mode = 2'd2;
      pulse_arm(1'b1);
      bus_cycle(32'h0000_1000, 1'b1, 32'h0BAD_0001, 1'b1);
      check("t3_read_no_trig", 32'(trig_b), 32'd0);
      bus_cycle(32'h0000_1000, 1'b0, 32'h600D_0002, 1'b1);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h02);
      exp_rec(8'h03, 32'h0000_1000, 32'h0BAD_0001);
      exp_rec(8'h06, 32'h0000_1000, 32'h600D_0002);
      collect(1'b0, 0);
      compare_dump("t3");

      // Cycles without a data strobe.
      trigger_rw_mode = 2'd0;
      pulse_arm(1'b1);
      bus_cycle(32'h0000_2000, 1'b0, 32'hFFFF_FFFF, 1'b0);
      bus_cycle(32'h0000_1000, 1'b1, 32'hFFFF_FFFF, 1'b0);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h02);
      exp_rec(8'h00, 32'h0000_2000, 32'h0000_0000);
      exp_rec(8'h05, 32'h0000_1000, 32'h0000_0000);
      collect(1'b1, 0);
      compare_dump("t4");

      // Reset in the middle of a dump, then a fresh capture.
      pulse_arm(1'b1);
      bus_cycle(32'h0000_1000, 1'b1, 32'h0000_00AB, 1'b1);
      collect(1'b0, 5);
      check("t6_partial", 32'(got.size()), 32'd5);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_valid", 32'(ov_b), 32'd0);
      check("t6_rst_data", 32'(od_b), 32'h00);
      check("t6_rst_armed", 32'(armed_b), 32'd0);
      check("t6_rst_trig", 32'(trig_b), 32'd0);
      check("t6_rst_end", 32'(de_b), 32'd0);
      reset = 1'b0;
      idle(2);
      pulse_arm(1'b1);
      bus_cycle(32'h0000_1000, 1'b0, 32'h1234_5678, 1'b1);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      exp_rec(8'h06, 32'h0000_1000, 32'h1234_5678);
      collect(1'b0, 0);
      compare_dump("t6");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
